// File: rtl/rp_lift_stream_pkg.sv
// rtl/rp_lift_stream_pkg.sv - shared constants, types and lift arithmetic for rp_lift_stream
package rp_lift_stream_pkg;

    localparam int RP_P      = 761;
    localparam int RP_Q      = 4591;
    localparam int RP_DEPTH  = 10;
    localparam int RP_D_SIZE = 13;
    localparam int RP_COEF_W = 13;
    localparam int RP_HALFQ  = (RP_Q - 1) / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [RP_COEF_W-1:0] data;
        logic [RP_DEPTH-1:0]  index;
        logic                 last;
    } beat_t;

    // Centred lift in COEF_W+2 signed bits, truncated; out-of-range digits wrap rather than saturate.
    function automatic logic [RP_COEF_W-1:0] lift(input logic [RP_D_SIZE-1:0] v,
                                                  input logic rounded,
                                                  input int halfq);
        logic signed [RP_COEF_W+1:0] ve;
        logic signed [RP_COEF_W+1:0] w;
        ve = (RP_COEF_W+2)'(v);
        w  = rounded ? (ve + ve + ve) - (RP_COEF_W+2)'(halfq) : ve - (RP_COEF_W+2)'(halfq);
        return w[RP_COEF_W-1:0];
    endfunction

endpackage

// File: rtl/rp_lift_stream_if.sv
// rtl/rp_lift_stream_if.sv - decoder write port plus lifted coefficient stream
interface rp_lift_stream_if;
    import rp_lift_stream_pkg::*;

    logic [RP_DEPTH-1:0]  cd_wr_addr;
    logic [RP_D_SIZE-1:0] cd_wr_data;
    logic                 cd_wr_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [RP_COEF_W-1:0] out_data;
    logic [RP_DEPTH-1:0]  out_index;
    logic                 out_last;

    modport slave (
        input  cd_wr_addr, cd_wr_data, cd_wr_en, out_ready,
        output out_valid, out_data, out_index, out_last
    );

    modport master (
        output cd_wr_addr, cd_wr_data, cd_wr_en, out_ready,
        input  out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/rp_lift_stream_bram.sv
// rtl/rp_lift_stream_bram.sv - simple dual-port buffer, 1-cycle read, write-first on address collision
module rp_lift_stream_bram #(
    parameter int D_SIZE  = 13,
    parameter int Q_DEPTH = 10
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [Q_DEPTH-1:0] wr_addr_i,
    input  logic [D_SIZE-1:0]  wr_data_i,
    input  logic [Q_DEPTH-1:0] rd_addr_i,
    output logic [D_SIZE-1:0]  rd_data_o
);

    logic [D_SIZE-1:0] mem_q [2**Q_DEPTH];
    logic [D_SIZE-1:0] rd_data_q;

    // Bypass lets the first drain read see a write landing in the dec_done cycle.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_q <= wr_data_i;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rp_lift_stream.sv
// rtl/rp_lift_stream.sv - collects decoded digits, lifts them and streams coefficients in index order
module rp_lift_stream
    import rp_lift_stream_pkg::*;
#(
    parameter int P       = RP_P,
    parameter int Q       = RP_Q,
    parameter int ROUNDED = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             dec_done_i,
    rp_lift_stream_if.slave  lift_if,
    output logic             frame_done_o,
    output logic             err_o
);

    localparam int HALFQ = (Q - 1) / 2;
    localparam int LIMIT = (ROUNDED != 0) ? (Q + 2) / 3 : Q;

    state_e               state_q, state_d;
    logic [15:0]          wr_cnt_q, wr_cnt_d;
    logic                 err_q, err_d;
    logic [RP_DEPTH:0]    rd_ptr_q, rd_ptr_d;
    logic                 rd_inflight_q;
    logic [RP_DEPTH-1:0]  rd_idx_q;
    logic                 rd_last_q;
    beat_t                skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0]           skid_cnt_q, skid_cnt_d;
    logic                 frame_done_q, frame_done_d;

    logic                 bram_we, rd_go, pop, wr_in_range, wr_data_high;
    logic [RP_DEPTH-1:0]  rd_addr;
    logic [RP_D_SIZE-1:0] rd_data;
    logic [2:0]           occ;
    beat_t                push_beat;

    rp_lift_stream_bram #(.D_SIZE(RP_D_SIZE), .Q_DEPTH(RP_DEPTH)) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (bram_we),
        .wr_addr_i (lift_if.cd_wr_addr),
        .wr_data_i (lift_if.cd_wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign wr_in_range  = 32'(lift_if.cd_wr_addr) < P;
    assign wr_data_high = 32'(lift_if.cd_wr_data) >= LIMIT;
    assign pop          = (skid_cnt_q != 2'd0) && lift_if.out_ready;
    assign push_beat    = {lift(rd_data, ROUNDED != 0, HALFQ), rd_idx_q, rd_last_q};
    // Entries the skid will hold after this cycle; a new read is safe only if that is at most one.
    assign occ          = {1'b0, skid_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        err_d        = err_q;
        rd_ptr_d     = rd_ptr_q;
        rd_go        = 1'b0;
        rd_addr      = rd_ptr_q[RP_DEPTH-1:0];
        bram_we      = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (lift_if.cd_wr_en) begin
                    if (wr_in_range) begin
                        bram_we  = 1'b1;
                        wr_cnt_d = wr_cnt_q + 16'd1;
                        if (wr_data_high) err_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (dec_done_i) begin
                    state_d  = ST_DRAIN;
                    if (32'(wr_cnt_d) != P) err_d = 1'b1;
                    rd_go    = 1'b1;
                    rd_addr  = '0;
                    rd_ptr_d = (RP_DEPTH+1)'(1);
                end
            end
            ST_DRAIN: begin
                if (lift_if.cd_wr_en) err_d = 1'b1;
                if ((32'(rd_ptr_q) < P) && (occ <= 3'd1)) begin
                    rd_go    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (pop && skid0_q.last) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (start_i) begin
            state_d  = ST_FILL;
            wr_cnt_d = '0;
            err_d    = 1'b0;
            rd_ptr_d = '0;
            rd_go    = 1'b0;
            bram_we  = 1'b0;
        end
    end

    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case ({pop, rd_inflight_q})
            2'b01: begin
                if (skid_cnt_q == 2'd0) skid0_d = push_beat;
                else                    skid1_d = push_beat;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b10: begin
                if (skid_cnt_q == 2'd2) skid0_d = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = push_beat;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = push_beat;
                end
            end
            default: ;
        endcase
        if (start_i) skid_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wr_cnt_q      <= '0;
            err_q         <= 1'b0;
            rd_ptr_q      <= '0;
            rd_inflight_q <= 1'b0;
            rd_idx_q      <= '0;
            rd_last_q     <= 1'b0;
            skid0_q       <= '0;
            skid1_q       <= '0;
            skid_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            err_q         <= err_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_inflight_q <= rd_go;
            rd_idx_q      <= rd_addr;
            rd_last_q     <= (32'(rd_addr) == P - 1);
            skid0_q       <= skid0_d;
            skid1_q       <= skid1_d;
            skid_cnt_q    <= skid_cnt_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign lift_if.out_valid = skid_cnt_q != 2'd0;
    assign lift_if.out_data  = skid0_q.data;
    assign lift_if.out_index = skid0_q.index;
    assign lift_if.out_last  = skid0_q.last && (skid_cnt_q != 2'd0);
    assign frame_done_o      = frame_done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_rp_lift_stream.sv
// tb/tb_rp_lift_stream.sv - directed bench for rp_lift_stream, Rq and Rounded instances in lockstep
module tb_rp_lift_stream;
    import rp_lift_stream_pkg::*;

    logic clk = 1'b0;
    logic rst, start, dec_done;
    logic fd_rq, fd_rd, err_rq, err_rd;

    rp_lift_stream_if if_rq ();
    rp_lift_stream_if if_rd ();

    assign if_rd.cd_wr_addr = if_rq.cd_wr_addr;
    assign if_rd.cd_wr_data = if_rq.cd_wr_data;
    assign if_rd.cd_wr_en   = if_rq.cd_wr_en;
    assign if_rd.out_ready  = if_rq.out_ready;

    rp_lift_stream #(.P(761), .Q(4591), .ROUNDED(0)) dut_rq (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dec_done_i(dec_done),
        .lift_if(if_rq), .frame_done_o(fd_rq), .err_o(err_rq)
    );

    rp_lift_stream #(.P(761), .Q(4591), .ROUNDED(1)) dut_rd (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dec_done_i(dec_done),
        .lift_if(if_rd), .frame_done_o(fd_rd), .err_o(err_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0]        v;
        logic signed [12:0] c_rq;
        logic signed [12:0] c_rd;
        bit                 bad_rq;
        bit                 bad_rd;
    } vec_t;

    vec_t vt [6];
    int   tab [761];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   exp_err_rq, exp_err_rd;

    task automatic chk(input string name, input integer act, input integer exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    function automatic int pat_id(input int pat, input int i);
        case (pat)
            0: return (i == 0) ? 0 : (i == 2) ? 2 : 1;
            1: return (i == 0) ? 0 : (i == 1) ? 3 : (i == 2) ? 4 : (i == 3) ? 5 : 3;
            2: return 4;
            3: return 0;
            4: return 3;
            default: return (i % 3 == 0) ? 0 : (i % 3 == 1) ? 3 : 4;
        endcase
    endfunction

    task automatic fill(input int pat, input bit rev, input int skip, input int dup_idx,
                        input bit bad, input bit do_start, input string tag);
        int addrs[$];
        int ids[$];
        int i, cnt;
        bit e_rq, e_rd;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 761; k++) begin
            i = rev ? 760 - k : k;
            if (i != skip) begin
                addrs.push_back(i);
                ids.push_back(pat_id(pat, i));
            end
            if (bad && k == 0) begin
                addrs.push_back(761);
                ids.push_back(3);
            end
        end
        if (dup_idx >= 0) begin
            addrs.push_back(dup_idx);
            ids.push_back(4);
        end
        e_rq = 1'b0; e_rd = 1'b0; cnt = 0;
        for (int w = 0; w < addrs.size(); w++) begin
            if_rq.cd_wr_en   = 1'b1;
            if_rq.cd_wr_addr = 10'(addrs[w]);
            if_rq.cd_wr_data = vt[ids[w]].v;
            dec_done         = (w == addrs.size() - 1);
            if (dec_done) begin
                @(negedge clk);
                chk({tag, "_fill_err_rq"}, err_rq, e_rq);
                chk({tag, "_fill_err_rd"}, err_rd, e_rd);
            end
            if (addrs[w] >= 761) begin
                e_rq = 1'b1; e_rd = 1'b1;
            end else begin
                tab[addrs[w]] = ids[w];
                cnt++;
                e_rq |= vt[ids[w]].bad_rq;
                e_rd |= vt[ids[w]].bad_rd;
            end
            @(posedge clk); #1;
            if (addrs[w] >= 761) begin
                if_rq.cd_wr_en = 1'b0;
                @(negedge clk);
                chk({tag, "_badaddr_err"}, {err_rq, err_rd}, 2'b11);
                @(posedge clk); #1;
            end
        end
        if_rq.cd_wr_en = 1'b0;
        dec_done       = 1'b0;
        exp_err_rq     = e_rq || (cnt != 761);
        exp_err_rd     = e_rd || (cnt != 761);
    endtask

    task automatic drain(input int mode, input int abort_at, input int rst_at,
                         input bit timing, input string tag);
        int cyc, beats, mm, first_v, fd_cyc, quiet_bad;
        bit rdy, prev_stall, stop;
        logic [12:0] pd_rq, pd_rd;
        logic [9:0]  pix;
        logic        pl;
        cyc = 1; beats = 0; mm = 0; first_v = -1; fd_cyc = -1;
        prev_stall = 1'b0; stop = 1'b0;
        pd_rq = '0; pd_rd = '0; pix = '0; pl = 1'b0;
        while (!stop && fd_cyc < 0 && cyc < 3000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            if_rq.out_ready = rdy;
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, "_err_rq"}, err_rq, exp_err_rq);
                chk({tag, "_err_rd"}, err_rd, exp_err_rd);
            end
            if (fd_rq) fd_cyc = cyc;
            if (if_rq.out_valid !== if_rd.out_valid || fd_rq !== fd_rd) mm++;
            if (if_rq.out_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (prev_stall && (if_rq.out_data !== pd_rq || if_rd.out_data !== pd_rd ||
                               if_rq.out_index !== pix || if_rq.out_last !== pl)) mm++;
            if (if_rq.out_valid === 1'b1 && rdy) begin
                if (beats > 760) mm++;
                else if (if_rq.out_index !== 10'(beats) || if_rd.out_index !== 10'(beats) ||
                         if_rq.out_last !== (beats == 760) ||
                         if_rq.out_data !== vt[tab[beats]].c_rq ||
                         if_rd.out_data !== vt[tab[beats]].c_rd) mm++;
                beats++;
            end
            prev_stall = (if_rq.out_valid === 1'b1) && !rdy;
            pd_rq = if_rq.out_data; pd_rd = if_rd.out_data;
            pix = if_rq.out_index; pl = if_rq.out_last;
            if (abort_at >= 0 && beats == abort_at) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                chk({tag, "_abort_valid"}, {if_rq.out_valid, if_rd.out_valid, fd_rq, fd_rd}, 4'b0000);
                stop = 1'b1;
            end else if (rst_at >= 0 && beats == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk({tag, "_rst_outputs"},
                    {if_rq.out_valid, if_rq.out_last, if_rq.out_data, if_rq.out_index, fd_rq, err_rq,
                     if_rd.out_valid, if_rd.out_last, if_rd.out_data, if_rd.out_index, fd_rd, err_rd}, 0);
                quiet_bad = 0;
                for (int c = 0; c < 800; c++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    if (if_rq.out_valid !== 1'b0 || if_rd.out_valid !== 1'b0 ||
                        fd_rq !== 1'b0 || fd_rd !== 1'b0) quiet_bad++;
                end
                chk({tag, "_rst_quiet"}, quiet_bad, 0);
                stop = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!stop) begin
            chk({tag, "_beats"}, beats, 761);
            chk({tag, "_beat_mismatch"}, mm, 0);
            if (timing) begin
                chk({tag, "_first_valid_cyc"}, first_v, 2);
                chk({tag, "_frame_done_cyc"}, fd_cyc, 763);
            end
        end
        if_rq.out_ready = 1'b1;
    endtask

    initial begin
        vt[0] = '{13'd0,    -13'sd2295, -13'sd2295, 1'b0, 1'b0};
        vt[1] = '{13'd2295,  13'sd0,    -13'sd3602, 1'b0, 1'b1};
        vt[2] = '{13'd4590,  13'sd2295,  13'sd3283, 1'b0, 1'b1};
        vt[3] = '{13'd765,  -13'sd1530,  13'sd0,    1'b0, 1'b0};
        vt[4] = '{13'd1530, -13'sd765,   13'sd2295, 1'b0, 1'b0};
        vt[5] = '{13'd1531, -13'sd764,   13'sd2298, 1'b0, 1'b1};
        for (int i = 0; i < 761; i++) tab[i] = 0;

        rst = 1'b1; start = 1'b0; dec_done = 1'b0;
        if_rq.cd_wr_en = 1'b0; if_rq.cd_wr_addr = '0; if_rq.cd_wr_data = '0;
        if_rq.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rq", {if_rq.out_valid, if_rq.out_last, if_rq.out_data, if_rq.out_index, fd_rq, err_rq}, 0);
        chk("reset_rd", {if_rd.out_valid, if_rd.out_last, if_rd.out_data, if_rd.out_index, fd_rd, err_rd}, 0);
        @(posedge clk); #1;

        fill(0, 1'b0, -1, -1, 1'b0, 1'b1, "f1");
        drain(0, -1, -1, 1'b1, "f1");
        fill(1, 1'b1, -1, -1, 1'b0, 1'b1, "f2");
        drain(1, -1, -1, 1'b0, "f2");
        fill(2, 1'b0, 5, -1, 1'b0, 1'b1, "f3");
        drain(2, -1, -1, 1'b0, "f3");
        fill(3, 1'b1, 9, 7, 1'b0, 1'b1, "f4");
        drain(0, -1, -1, 1'b1, "f4");
        fill(4, 1'b0, -1, -1, 1'b1, 1'b1, "f5");
        drain(0, -1, -1, 1'b1, "f5");
        fill(2, 1'b0, -1, -1, 1'b0, 1'b1, "f6");
        drain(0, 100, -1, 1'b0, "f6");
        fill(5, 1'b0, -1, -1, 1'b0, 1'b0, "f6b");
        drain(0, -1, -1, 1'b1, "f6b");
        fill(3, 1'b0, -1, -1, 1'b0, 1'b1, "f7");
        drain(0, -1, 50, 1'b0, "f7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
